// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: one shared 2048-clock period, per-motor duty/direction
// shadowed at period boundaries, and a dead interval on every direction reversal.
module mtr_drv #(
  parameter int unsigned DEAD_PERIODS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic [10:0] lft_spd,
  input  logic        lft_rev,
  input  logic [10:0] rght_spd,
  input  logic        rght_rev,
  output logic        lft_fwd_pwm,
  output logic        lft_rev_pwm,
  output logic        rght_fwd_pwm,
  output logic        rght_rev_pwm,
  output logic        pwm_sync
);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  localparam logic [1:0] DeadInit = 2'(DEAD_PERIODS - 1);

  logic [10:0]      cnt_q, cnt_d;
  logic             sync_q, sync_d;
  logic             boundary;
  logic [1:0][10:0] spd_cmd;
  logic [1:0]       rev_cmd;
  state_e           state_q [2];
  state_e           state_d [2];
  logic [1:0][10:0] duty_q, duty_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0][1:0]  dead_q, dead_d;
  logic [1:0]       fwd_q, fwd_d;
  logic [1:0]       bwd_q, bwd_d;
  logic [1:0]       motor_on;

  // Index 0 is the left motor, index 1 the right motor.
  assign spd_cmd = {rght_spd, lft_spd};
  assign rev_cmd = {rght_rev, lft_rev};

  assign boundary = (cnt_q == 11'h7FF);

  always_comb begin
    cnt_d    = cnt_q + 11'd1;
    sync_d   = (cnt_q == 11'd0);
    motor_on = '0;
    duty_d   = duty_q;
    dir_d    = dir_q;
    dead_d   = dead_q;
    fwd_d    = '0;
    bwd_d    = '0;
    for (int m = 0; m < 2; m++) begin
      state_d[m] = state_q[m];
      if (!pwr_up) begin
        // Power drop wins over everything and acts mid-period.
        state_d[m] = StIdle;
        duty_d[m]  = '0;
      end else if (boundary) begin
        unique case (state_q[m])
          StIdle: begin
            duty_d[m]  = spd_cmd[m];
            dir_d[m]   = rev_cmd[m];
            state_d[m] = StRun;
          end
          StRun: begin
            if (rev_cmd[m] == dir_q[m]) begin
              duty_d[m] = spd_cmd[m];
            end else begin
              duty_d[m]  = '0;
              dead_d[m]  = DeadInit;
              state_d[m] = StDead;
            end
          end
          StDead: begin
            if (dead_q[m] != 2'd0) begin
              dead_d[m] = dead_q[m] - 2'd1;
            end else begin
              duty_d[m]  = spd_cmd[m];
              dir_d[m]   = rev_cmd[m];
              state_d[m] = StRun;
            end
          end
          default: state_d[m] = StIdle;
        endcase
      end
      motor_on[m] = pwr_up && (state_q[m] == StRun) && (cnt_q < duty_q[m]);
      fwd_d[m]    = motor_on[m] && !dir_q[m];
      bwd_d[m]    = motor_on[m] && dir_q[m];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sync_q     <= 1'b0;
      state_q[0] <= StIdle;
      state_q[1] <= StIdle;
      duty_q     <= '0;
      dir_q      <= '0;
      dead_q     <= '0;
      fwd_q      <= '0;
      bwd_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sync_q     <= sync_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      dead_q     <= dead_d;
      fwd_q      <= fwd_d;
      bwd_q      <= bwd_d;
    end
  end

  assign lft_fwd_pwm  = fwd_q[0];
  assign lft_rev_pwm  = bwd_q[0];
  assign rght_fwd_pwm = fwd_q[1];
  assign rght_rev_pwm = bwd_q[1];
  assign pwm_sync     = sync_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: per-clock period-level reference model plus per-scenario
// high-clock counts per PWM period.
module tb_mtr_drv;
  localparam int DP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwr_up = 1'b0;
  logic [10:0] lft_spd = '0;
  logic        lft_rev = 1'b0;
  logic [10:0] rght_spd = '0;
  logic        rght_rev = 1'b0;
  logic        lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, pwm_sync;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mtr_drv #(.DEAD_PERIODS(DP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwr_up      (pwr_up),
    .lft_spd     (lft_spd),
    .lft_rev     (lft_rev),
    .rght_spd    (rght_spd),
    .rght_rev    (rght_rev),
    .lft_fwd_pwm (lft_fwd_pwm),
    .lft_rev_pwm (lft_rev_pwm),
    .rght_fwd_pwm(rght_fwd_pwm),
    .rght_rev_pwm(rght_rev_pwm),
    .pwm_sync    (pwm_sync)
  );

  // Reference model: mode 0 idle, 1 driving, 2 dead; one entry per motor (0 left, 1 right).
  int       cnt_m = 0;
  int       mode_m [2] = '{0, 0};
  int       duty_m [2] = '{0, 0};
  bit       dir_m [2] = '{1'b0, 1'b0};
  int       dleft_m [2] = '{0, 0};
  int       spd_v [2];
  bit       rev_v [2];
  bit       on_v;
  logic [4:0] exp_v, act_v;

  always @(posedge clk or negedge rst_n) begin : monitor
    if (!rst_n) begin
      cnt_m = 0;
      for (int m = 0; m < 2; m++) begin
        mode_m[m] = 0; duty_m[m] = 0; dir_m[m] = 1'b0; dleft_m[m] = 0;
      end
      exp_v = '0;
    end else begin
      spd_v[0] = int'(lft_spd);  rev_v[0] = lft_rev;
      spd_v[1] = int'(rght_spd); rev_v[1] = rght_rev;
      exp_v = '0;
      exp_v[0] = (cnt_m == 0);
      for (int m = 0; m < 2; m++) begin
        on_v = pwr_up && (mode_m[m] == 1) && (cnt_m < duty_m[m]);
        exp_v[4-2*m] = on_v && !dir_m[m];
        exp_v[3-2*m] = on_v && dir_m[m];
        if (!pwr_up) begin
          mode_m[m] = 0; duty_m[m] = 0;
        end else if (cnt_m == 2047) begin
          case (mode_m[m])
            0: begin duty_m[m] = spd_v[m]; dir_m[m] = rev_v[m]; mode_m[m] = 1; end
            1: begin
              if (rev_v[m] == dir_m[m]) duty_m[m] = spd_v[m];
              else begin duty_m[m] = 0; dleft_m[m] = DP - 1; mode_m[m] = 2; end
            end
            default: begin
              if (dleft_m[m] > 0) dleft_m[m]--;
              else begin duty_m[m] = spd_v[m]; dir_m[m] = rev_v[m]; mode_m[m] = 1; end
            end
          endcase
        end
      end
      cnt_m = (cnt_m + 1) % 2048;
    end
    #1;
    act_v = {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, pwm_sync};
    vectors++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs t=%0t got lf/lr/rf/rr/sync=%b expected %b", $time, act_v, exp_v);
    end
    vectors++;
    if (((lft_fwd_pwm & lft_rev_pwm) | (rght_fwd_pwm & rght_rev_pwm)) !== 1'b0) begin
      errors++;
      $display("FAIL exclusion t=%0t got lf/lr/rf/rr=%b%b%b%b expected no pair high", $time,
               lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm);
    end
  end

  typedef struct {
    int          chg;
    logic [10:0] ls;
    logic        lr;
    logic [10:0] rs;
    logic        rr;
    int          elf, elr, erf, err;
  } row_t;

  task automatic wait_cnt(input int c);
    for (int i = 0; i < 4096 && cnt_m != c; i++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_sync(output int n);
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (pwm_sync !== 1'b1 && n < 4096);
    vectors++;
    if (pwm_sync !== 1'b1) begin
      errors++;
      $display("FAIL sync_timeout got pwm_sync=%b expected 1 within 4096 clocks", pwm_sync);
    end
  endtask

  // Counts high clocks per output over one full period starting at the next pwm_sync.
  task automatic count_period(input int chg_at, input logic [10:0] ls, input logic lr_i,
                              input logic [10:0] rs, input logic rr_i, output int gap,
                              output int n_lf, output int n_lr, output int n_rf,
                              output int n_rr);
    wait_sync(gap);
    n_lf = 0; n_lr = 0; n_rf = 0; n_rr = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i > 0) begin @(posedge clk); #2; end
      n_lf += int'(lft_fwd_pwm);
      n_lr += int'(lft_rev_pwm);
      n_rf += int'(rght_fwd_pwm);
      n_rr += int'(rght_rev_pwm);
      if (i == chg_at) begin
        lft_spd = ls; lft_rev = lr_i; rght_spd = rs; rght_rev = rr_i;
      end
    end
  endtask

  task automatic test_reset();
    pwr_up = 1'b1; lft_spd = 11'd512; lft_rev = 1'b0; rght_spd = 11'd0; rght_rev = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, pwm_sync} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00000",
               {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, pwm_sync});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    int g, lf, lr, rf, rr;
    count_period(-1, 11'd512, 1'b0, 11'd0, 1'b0, g, lf, lr, rf, rr);
    vectors++;
    if (g != 1 || lf != 0 || lr != 0) begin
      errors++;
      $display("FAIL idle_period got gap=%0d lf=%0d lr=%0d expected gap=1 lf=0 lr=0", g, lf, lr);
    end
    count_period(-1, 11'd512, 1'b0, 11'd0, 1'b0, g, lf, lr, rf, rr);
    vectors++;
    if (g != 1 || lf != 512 || lr != 0 || rf != 0 || rr != 0) begin
      errors++;
      $display("FAIL fwd_512 got gap=%0d lf=%0d lr=%0d rf=%0d rr=%0d expected 1 512 0 0 0",
               g, lf, lr, rf, rr);
    end
  endtask

  task automatic test_duty_extremes();
    row_t rows [4];
    int g, lf, lr, rf, rr;
    rows[0] = '{-1,   11'd512, 1'b0, 11'd2047, 1'b0, 512, 0, 0,    0};
    rows[1] = '{1000, 11'd512, 1'b0, 11'd100,  1'b0, 512, 0, 2047, 0};
    rows[2] = '{1000, 11'd512, 1'b0, 11'd900,  1'b0, 512, 0, 100,  0};
    rows[3] = '{1000, 11'd300, 1'b0, 11'd900,  1'b0, 512, 0, 900,  0};
    rght_spd = 11'd2047;
    for (int i = 0; i < 4; i++) begin
      count_period(rows[i].chg, rows[i].ls, rows[i].lr, rows[i].rs, rows[i].rr,
                   g, lf, lr, rf, rr);
      vectors++;
      if (lf != rows[i].elf || lr != rows[i].elr || rf != rows[i].erf || rr != rows[i].err) begin
        errors++;
        $display("FAIL duty_row%0d got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                 lf, lr, rf, rr, rows[i].elf, rows[i].elr, rows[i].erf, rows[i].err);
      end
    end
  endtask

  task automatic test_reversal();
    row_t rows [3];
    int g, lf, lr, rf, rr;
    rows[0] = '{1000, 11'd300, 1'b1, 11'd900, 1'b0, 300, 0,   900, 0};
    rows[1] = '{-1,   11'd300, 1'b1, 11'd900, 1'b0, 0,   0,   900, 0};
    rows[2] = '{-1,   11'd300, 1'b1, 11'd900, 1'b0, 0,   300, 900, 0};
    for (int i = 0; i < 3; i++) begin
      count_period(rows[i].chg, rows[i].ls, rows[i].lr, rows[i].rs, rows[i].rr,
                   g, lf, lr, rf, rr);
      vectors++;
      if (lf != rows[i].elf || lr != rows[i].elr || rf != rows[i].erf || rr != rows[i].err) begin
        errors++;
        $display("FAIL reversal_row%0d got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                 lf, lr, rf, rr, rows[i].elf, rows[i].elr, rows[i].erf, rows[i].err);
      end
    end
  endtask

  task automatic test_reversal_glitch();
    row_t rows [3];
    int g, lf, lr, rf, rr;
    rows[0] = '{1000, 11'd300, 1'b0, 11'd900, 1'b0, 0, 300, 900, 0};
    rows[1] = '{1000, 11'd300, 1'b1, 11'd900, 1'b0, 0, 0,   900, 0};
    rows[2] = '{-1,   11'd300, 1'b1, 11'd900, 1'b0, 0, 300, 900, 0};
    for (int i = 0; i < 3; i++) begin
      count_period(rows[i].chg, rows[i].ls, rows[i].lr, rows[i].rs, rows[i].rr,
                   g, lf, lr, rf, rr);
      vectors++;
      if (lf != rows[i].elf || lr != rows[i].elr || rf != rows[i].erf || rr != rows[i].err) begin
        errors++;
        $display("FAIL glitch_row%0d got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                 lf, lr, rf, rr, rows[i].elf, rows[i].elr, rows[i].erf, rows[i].err);
      end
    end
  endtask

  task automatic test_pwr_drop();
    int g, lf, lr, rf, rr, highs;
    count_period(1000, 11'd300, 1'b1, 11'd1000, 1'b0, g, lf, lr, rf, rr);
    vectors++;
    if (lr != 300 || rf != 900) begin
      errors++;
      $display("FAIL pwr_pre got lr=%0d rf=%0d expected 300 900", lr, rf);
    end
    wait_cnt(100);
    vectors++;
    if ({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm} !== 4'b0110) begin
      errors++;
      $display("FAIL pwr_active got %b%b%b%b expected 0110",
               lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm);
    end
    pwr_up = 1'b0;
    @(posedge clk); #2;
    vectors++;
    if ({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm} !== 4'b0000) begin
      errors++;
      $display("FAIL pwr_drop got %b%b%b%b expected 0000",
               lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm);
    end
    wait_cnt(500);
    pwr_up = 1'b1;
    highs = 0;
    for (int i = 0; i < 4096 && cnt_m != 2047; i++) begin
      @(posedge clk); #2;
      highs += int'(lft_fwd_pwm) + int'(lft_rev_pwm) + int'(rght_fwd_pwm) + int'(rght_rev_pwm);
    end
    vectors++;
    if (highs != 0) begin
      errors++;
      $display("FAIL pwr_reraise_low got %0d high clocks expected 0", highs);
    end
    count_period(-1, 11'd300, 1'b1, 11'd1000, 1'b0, g, lf, lr, rf, rr);
    vectors++;
    if (lf != 0 || lr != 300 || rf != 1000 || rr != 0) begin
      errors++;
      $display("FAIL pwr_resume got %0d/%0d/%0d/%0d expected 0/300/1000/0", lf, lr, rf, rr);
    end
  endtask

  task automatic test_reset_mid();
    int g, lf, lr, rf, rr;
    wait_cnt(1500);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, pwm_sync} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid got %b expected 00000",
               {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, pwm_sync});
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    count_period(-1, 11'd300, 1'b1, 11'd1000, 1'b0, g, lf, lr, rf, rr);
    vectors++;
    if (g != 1 || lf + lr + rf + rr != 0) begin
      errors++;
      $display("FAIL reset_restart got gap=%0d highs=%0d expected gap=1 highs=0",
               g, lf + lr + rf + rr);
    end
    count_period(-1, 11'd300, 1'b1, 11'd1000, 1'b0, g, lf, lr, rf, rr);
    vectors++;
    if (lf != 0 || lr != 300 || rf != 1000 || rr != 0) begin
      errors++;
      $display("FAIL reset_rerun got %0d/%0d/%0d/%0d expected 0/300/1000/0", lf, lr, rf, rr);
    end
  endtask

  task automatic test_random();
    logic [10:0] v;
    for (int i = 0; i < 8 * 2048; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 299) == 0) begin
        v = 11'($urandom);
        case ($urandom_range(0, 3))
          0: lft_spd = 11'd0;
          1: lft_spd = 11'd2047;
          default: lft_spd = v;
        endcase
      end
      if ($urandom_range(0, 299) == 0) rght_spd = 11'($urandom);
      if ($urandom_range(0, 499) == 0) lft_rev = ~lft_rev;
      if ($urandom_range(0, 499) == 0) rght_rev = ~rght_rev;
      if ($urandom_range(0, 2999) == 0) pwr_up = ~pwr_up;
    end
    pwr_up = 1'b1;
    repeat (4) @(posedge clk);
    #2;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_duty_extremes();
    test_reversal();
    test_reversal_glitch();
    test_pwr_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
